// File: rtl/csr_uart_fifo.sv
// FIFO-buffered 8N1 UART on the CSR bus: data CSR at BASE_ADDR, status/control at BASE_ADDR+1,
// fixed baud divider, overrun/framing flags and a level interrupt.
module csr_uart_fifo #(
  parameter logic [11:0] BASE_ADDR     = 12'hbc0,
  parameter int          CLOCK_RATE    = 12_000_000,
  parameter int          BAUD_RATE     = 115200,
  parameter int          TX_DEPTH_LOG2 = 3,
  parameter int          RX_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        read,
  input  logic [2:0]  modify,
  input  logic [31:0] wdata,
  input  logic [11:0] addr,
  output logic [31:0] rdata,
  output logic        valid,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  localparam logic [15:0] CLOCK_DIV = 16'(CLOCK_RATE / BAUD_RATE);
  localparam int TXW = TX_DEPTH_LOG2;
  localparam int RXW = RX_DEPTH_LOG2;
  localparam int TXC = TX_DEPTH_LOG2 + 1;
  localparam int RXC = RX_DEPTH_LOG2 + 1;
  localparam int TX_N = 2 ** TX_DEPTH_LOG2;
  localparam int RX_N = 2 ** RX_DEPTH_LOG2;
  localparam logic [TXC-1:0] TX_FULL_CNT = {1'b1, {TXW{1'b0}}};
  localparam logic [RXC-1:0] RX_FULL_CNT = {1'b1, {RXW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic [7:0]     tx_mem_q [TX_N];
  logic [7:0]     tx_mem_d [TX_N];
  logic [7:0]     rx_mem_q [RX_N];
  logic [7:0]     rx_mem_d [RX_N];
  logic [TXW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [RXW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [TXC-1:0] tx_count_q, tx_count_d;
  logic [RXC-1:0] rx_count_q, rx_count_d;
  uart_state_e    tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [15:0]    tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0]     tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic           tx_q, tx_d, rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
  logic           rx_ferr_wait_q, rx_ferr_wait_d;
  logic           overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic           ie_tx_q, ie_tx_d, ie_rx_q, ie_rx_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           valid_q, valid_d, irq_q, irq_d;

  logic data_hit_s, stat_hit_s, tx_empty_s, tx_full_s, rx_empty_s, rx_full_s, tx_busy_s;
  logic tx_push_s, tx_pop_s, rx_push_s, rx_pop_s, rx_wr_s;
  logic [7:0] rx_head_s;
  logic unused_s;

  assign unused_s   = ^{read, wdata[31:8]};
  assign data_hit_s = (addr == BASE_ADDR);
  assign stat_hit_s = (addr == BASE_ADDR + 12'd1);
  assign tx_empty_s = (tx_count_q == {TXC{1'b0}});
  assign tx_full_s  = (tx_count_q == TX_FULL_CNT);
  assign rx_empty_s = (rx_count_q == {RXC{1'b0}});
  assign rx_full_s  = (rx_count_q == RX_FULL_CNT);
  assign tx_busy_s  = (tx_state_q != S_IDLE);
  assign rx_head_s  = rx_empty_s ? 8'd0 : rx_mem_q[rx_rptr_q];

  // Next-state logic: TX engine, CSR decode, RX engine, FIFO bookkeeping, read data and irq.
  always_comb begin
    tx_mem_d = tx_mem_q;  rx_mem_d = rx_mem_q;
    tx_wptr_d = tx_wptr_q; tx_rptr_d = tx_rptr_q; tx_count_d = tx_count_q;
    rx_wptr_d = rx_wptr_q; rx_rptr_d = rx_rptr_q; rx_count_d = rx_count_q;
    tx_state_d = tx_state_q; tx_cnt_d = tx_cnt_q; tx_bit_d = tx_bit_q; tx_shift_d = tx_shift_q;
    rx_state_d = rx_state_q; rx_cnt_d = rx_cnt_q; rx_bit_d = rx_bit_q; rx_shift_d = rx_shift_q;
    tx_d = tx_q; rx_s1_d = rx; rx_s2_d = rx_s1_q; rx_ferr_wait_d = rx_ferr_wait_q;
    overrun_d = overrun_q; frame_err_d = frame_err_q; ie_tx_d = ie_tx_q; ie_rx_d = ie_rx_q;
    tx_push_s = 1'b0; tx_pop_s = 1'b0; rx_push_s = 1'b0; rx_pop_s = 1'b0; rx_wr_s = 1'b0;

    // The stop bit holds CLOCK_DIV-1 cycles in STOP; the IDLE cycle supplies the last one.
    case (tx_state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!tx_empty_s) begin
          tx_pop_s   = 1'b1;
          tx_shift_d = tx_mem_q[tx_rptr_q];
          tx_d       = 1'b0;
          tx_cnt_d   = CLOCK_DIV - 16'd1;
          tx_state_d = S_START;
        end else begin
          tx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_d = tx_shift_q[0]; tx_bit_d = 3'd0; tx_cnt_d = CLOCK_DIV - 16'd1; tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          if (tx_bit_q == 3'd7) begin
            tx_d = 1'b1; tx_cnt_d = CLOCK_DIV - 16'd2; tx_state_d = S_STOP;
          end else begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_d       = tx_shift_q[1];
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_cnt_d   = CLOCK_DIV - 16'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          tx_state_d = S_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q - 16'd1;
        end
      end
      default: begin
        tx_d = 1'b1; tx_state_d = S_IDLE;
      end
    endcase

    if (data_hit_s) begin
      case (modify)
        3'b001:  tx_push_s = !tx_full_s || tx_pop_s;
        3'b010:  rx_pop_s  = !rx_empty_s;
        default: begin end
      endcase
    end else if (stat_hit_s) begin
      case (modify)
        3'b001: begin
          ie_tx_d = wdata[1]; ie_rx_d = wdata[0];
        end
        3'b011: begin
          overrun_d   = wdata[3] ? 1'b0 : overrun_q;
          frame_err_d = wdata[4] ? 1'b0 : frame_err_q;
        end
        default: begin end
      endcase
    end else begin
      tx_push_s = 1'b0;
    end

    // Flag events from the line take priority over a same-cycle software clear.
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_s2_q) begin
          rx_state_d = S_START; rx_cnt_d = CLOCK_DIV >> 1;
        end else begin
          rx_state_d = S_IDLE;
        end
      end
      S_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (!rx_s2_q) begin
            rx_state_d = S_DATA; rx_cnt_d = CLOCK_DIV - 16'd1; rx_bit_d = 3'd0;
          end else begin
            rx_state_d = S_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = CLOCK_DIV - 16'd1;
          if (rx_bit_q == 3'd7) begin
            rx_state_d = S_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (rx_cnt_q != 16'd0) begin
          rx_cnt_d = rx_cnt_q - 16'd1;
        end else if (rx_s2_q) begin
          rx_push_s = !rx_ferr_wait_q; rx_ferr_wait_d = 1'b0; rx_state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1; rx_ferr_wait_d = 1'b1;
        end
      end
      default: begin
        rx_state_d = S_IDLE;
      end
    endcase

    rx_wr_s   = rx_push_s && (!rx_full_s || rx_pop_s);
    overrun_d = (rx_push_s && !rx_wr_s) ? 1'b1 : overrun_d;

    if (tx_push_s) begin
      tx_mem_d[tx_wptr_q] = wdata[7:0];
      tx_wptr_d = tx_wptr_q + TXW'(1'b1);
    end else begin
      tx_wptr_d = tx_wptr_q;
    end
    tx_rptr_d = tx_pop_s ? tx_rptr_q + TXW'(1'b1) : tx_rptr_q;
    case ({tx_push_s, tx_pop_s})
      2'b10:   tx_count_d = tx_count_q + TXC'(1'b1);
      2'b01:   tx_count_d = tx_count_q - TXC'(1'b1);
      default: tx_count_d = tx_count_q;
    endcase

    if (rx_wr_s) begin
      rx_mem_d[rx_wptr_q] = rx_shift_q;
      rx_wptr_d = rx_wptr_q + RXW'(1'b1);
    end else begin
      rx_wptr_d = rx_wptr_q;
    end
    rx_rptr_d = rx_pop_s ? rx_rptr_q + RXW'(1'b1) : rx_rptr_q;
    case ({rx_wr_s, rx_pop_s})
      2'b10:   rx_count_d = rx_count_q + RXC'(1'b1);
      2'b01:   rx_count_d = rx_count_q - RXC'(1'b1);
      default: rx_count_d = rx_count_q;
    endcase

    valid_d = data_hit_s || stat_hit_s;
    if (data_hit_s) begin
      rdata_d = {22'd0, tx_full_s, rx_empty_s, rx_head_s};
    end else if (stat_hit_s) begin
      rdata_d = {8'd0, 8'(tx_count_q), 8'(rx_count_q), 3'd0,
                 frame_err_q, overrun_q, tx_busy_s, ie_tx_q, ie_rx_q};
    end else begin
      rdata_d = 32'd0;
    end
    irq_d = (ie_rx_q && !rx_empty_s) || (ie_tx_q && tx_empty_s && !tx_busy_s);
  end

  // FIFO storage needs no reset: the pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      tx_wptr_q <= '0; tx_rptr_q <= '0; tx_count_q <= '0;
      rx_wptr_q <= '0; rx_rptr_q <= '0; rx_count_q <= '0;
      tx_state_q <= S_IDLE; tx_cnt_q <= 16'd0; tx_bit_q <= 3'd0; tx_shift_q <= 8'd0;
      rx_state_q <= S_IDLE; rx_cnt_q <= 16'd0; rx_bit_q <= 3'd0; rx_shift_q <= 8'd0;
      tx_q <= 1'b1; rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_ferr_wait_q <= 1'b0;
      overrun_q <= 1'b0; frame_err_q <= 1'b0; ie_tx_q <= 1'b0; ie_rx_q <= 1'b0;
      rdata_q <= 32'd0; valid_q <= 1'b0; irq_q <= 1'b0;
    end else begin
      tx_wptr_q <= tx_wptr_d; tx_rptr_q <= tx_rptr_d; tx_count_q <= tx_count_d;
      rx_wptr_q <= rx_wptr_d; rx_rptr_q <= rx_rptr_d; rx_count_q <= rx_count_d;
      tx_state_q <= tx_state_d; tx_cnt_q <= tx_cnt_d; tx_bit_q <= tx_bit_d; tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d; rx_cnt_q <= rx_cnt_d; rx_bit_q <= rx_bit_d; rx_shift_q <= rx_shift_d;
      tx_q <= tx_d; rx_s1_q <= rx_s1_d; rx_s2_q <= rx_s2_d; rx_ferr_wait_q <= rx_ferr_wait_d;
      overrun_q <= overrun_d; frame_err_q <= frame_err_d; ie_tx_q <= ie_tx_d; ie_rx_q <= ie_rx_d;
      rdata_q <= rdata_d; valid_q <= valid_d; irq_q <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign tx    = tx_q;
  assign irq   = irq_q;
endmodule

// File: tb/tb_csr_uart_fifo.sv
// Directed bench for csr_uart_fifo with CLOCK_DIV=16 and 8-deep FIFOs.
module tb_csr_uart_fifo;
  localparam logic [11:0] BASE = 12'hbc0;
  localparam logic [11:0] STAT = 12'hbc1;

  logic        clk = 1'b0;
  logic        rstn, read, valid, rx, tx, irq;
  logic [2:0]  modify;
  logic [31:0] wdata, rdata;
  logic [11:0] addr;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  csr_uart_fifo #(.BASE_ADDR(BASE), .CLOCK_RATE(16), .BAUD_RATE(1),
                  .TX_DEPTH_LOG2(3), .RX_DEPTH_LOG2(3)) dut (
    .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
    .rdata(rdata), .valid(valid), .rx(rx), .tx(tx), .irq(irq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the modify takes effect at the next posedge.
  task automatic csr_write(input logic [11:0] a, input logic [2:0] m, input logic [31:0] d);
    addr = a; modify = m; wdata = d;
    @(negedge clk);
    modify = 3'b000;
  endtask

  task automatic csr_read(input logic [11:0] a, output logic [31:0] d, output logic v);
    addr = a; modify = 3'b000;
    @(negedge clk);
    d = rdata; v = valid;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (16) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  // Waits for a falling edge on tx, checks its cycle, then samples each bit mid-way.
  task automatic check_frame(input logic [7:0] b, input int exp_fall, input string tag);
    int n;
    logic [9:0] got;
    n = 0;
    while (tx !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    while (tx !== 1'b0 && n < 800) begin @(negedge clk); n++; end
    chk({tag, " fall cycle"}, cyc, exp_fall);
    repeat (8) @(negedge clk);
    got[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (16) @(negedge clk);
      got[i] = tx;
    end
    chk({tag, " frame bits"}, {22'd0, got}, {22'd0, 1'b1, b, 1'b0});
  endtask

  logic [31:0] d;
  logic        v;
  logic [7:0]  pat;
  logic        exp_b;
  int          bad;
  int          base;

  initial begin
    rstn = 1'b0; read = 1'b0; modify = 3'b000; wdata = 32'd0; addr = BASE; rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset tx", {31'd0, tx}, 32'd1);
    chk("reset irq", {31'd0, irq}, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    rstn = 1'b1;
    csr_read(BASE, d, v);
    chk("idle data", d, 32'h0000_0100);
    chk("data valid", {31'd0, v}, 32'd1);
    csr_read(STAT, d, v);
    chk("idle status", d, 32'd0);
    csr_read(12'h123, d, v);
    chk("miss rdata", d, 32'd0);
    chk("miss valid", {31'd0, v}, 32'd0);

    // Single 0xA5 frame, bit-exact
    pat = 8'ha5;
    csr_write(BASE, 3'b001, 32'h0000_00a5);
    chk("tx before fall", {31'd0, tx}, 32'd1);
    addr = STAT;
    for (int i = 0; i < 10; i++) begin
      exp_b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : pat[i-1];
      bad = 0;
      for (int j = 0; j < 16; j++) begin
        @(negedge clk);
        if (tx !== exp_b) bad++;
        if (i == 1 && j == 0) chk("busy status", rdata, 32'h0000_0004);
      end
      chk($sformatf("a5 bit%0d bad samples", i), bad, 32'd0);
    end

    // TX full drop and back-to-back frames
    csr_write(BASE, 3'b001, 32'h0000_00ff);
    base = cyc + 1;
    for (int k = 1; k <= 9; k++) csr_write(BASE, 3'b001, k);
    csr_read(STAT, d, v);
    chk("tx count 8", d, 32'h0008_0004);
    csr_read(BASE, d, v);
    chk("tx full flag", d, 32'h0000_0300);
    for (int k = 1; k <= 8; k++) check_frame(8'(k), base + 160 * k, $sformatf("frame%0d", k));
    repeat (24) @(negedge clk);
    chk("tx idle after burst", {31'd0, tx}, 32'd1);
    csr_read(STAT, d, v);
    chk("status after burst", d, 32'd0);

    // RX two frames and pops
    send_rx(8'h3c, 1'b1);
    send_rx(8'hc3, 1'b1);
    repeat (4) @(negedge clk);
    csr_read(BASE, d, v);
    chk("rx head 3c", d, 32'h0000_003c);
    csr_read(STAT, d, v);
    chk("rx count 2", d, 32'h0000_0200);
    csr_write(BASE, 3'b010, 32'd0);
    csr_read(BASE, d, v);
    chk("rx head c3", d, 32'h0000_00c3);
    csr_write(BASE, 3'b010, 32'd0);
    csr_read(BASE, d, v);
    chk("rx empty", d, 32'h0000_0100);

    // RX overrun
    for (int k = 0; k < 9; k++) send_rx(8'h10 + 8'(k), 1'b1);
    repeat (4) @(negedge clk);
    csr_read(STAT, d, v);
    chk("overrun status", d, 32'h0000_0808);
    csr_read(BASE, d, v);
    chk("overrun head", d, 32'h0000_0010);
    csr_write(STAT, 3'b011, 32'h0000_0008);
    csr_read(STAT, d, v);
    chk("overrun cleared", d, 32'h0000_0800);
    for (int k = 0; k < 7; k++) csr_write(BASE, 3'b010, 32'd0);
    csr_read(BASE, d, v);
    chk("last kept byte", d, 32'h0000_0017);
    csr_write(BASE, 3'b010, 32'd0);
    csr_read(BASE, d, v);
    chk("ninth byte lost", d, 32'h0000_0100);

    // Framing error and glitch rejection
    send_rx(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    csr_read(STAT, d, v);
    chk("frame err", d, 32'h0000_0010);
    csr_write(STAT, 3'b011, 32'h0000_0010);
    csr_read(STAT, d, v);
    chk("frame err cleared", d, 32'd0);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    csr_read(STAT, d, v);
    chk("glitch no frame", d, 32'd0);
    send_rx(8'h5a, 1'b1);
    repeat (4) @(negedge clk);
    csr_read(BASE, d, v);
    chk("frame after glitch", d, 32'h0000_005a);
    csr_write(BASE, 3'b010, 32'd0);

    // Interrupts and reset mid-frame
    csr_write(STAT, 3'b001, 32'h0000_0003);
    chk("irq not yet", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq tx empty", {31'd0, irq}, 32'd1);
    csr_write(BASE, 3'b001, 32'h0000_0042);
    chk("irq before pop", {31'd0, irq}, 32'd1);
    csr_write(BASE, 3'b001, 32'h0000_0043);
    chk("irq after pop", {31'd0, irq}, 32'd0);
    chk("tx start bit", {31'd0, tx}, 32'd0);
    send_rx(8'h77, 1'b1);
    repeat (2) @(negedge clk);
    chk("irq rx pending", {31'd0, irq}, 32'd1);
    chk("second frame start", {31'd0, tx}, 32'd0);
    csr_read(STAT, d, v);
    chk("status mid frame", d, 32'h0000_0107);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid reset tx", {31'd0, tx}, 32'd1);
    chk("mid reset irq", {31'd0, irq}, 32'd0);
    chk("mid reset valid", {31'd0, valid}, 32'd0);
    chk("mid reset rdata", rdata, 32'd0);
    rstn = 1'b1;
    csr_read(STAT, d, v);
    chk("status after reset", d, 32'd0);
    csr_read(BASE, d, v);
    chk("data after reset", d, 32'h0000_0100);
    bad = 0;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    chk("tx quiet after reset", bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_uart_fifo.md
Name: csr_uart_fifo

Overview:
Buffered, interrupt-capable UART on the CSR bus, with 8N1 framing and a fixed baud divider. Successor to the single-character CSR UART: both directions get parametrised-depth FIFOs, and the block adds a status/control CSR, overrun and framing-error flags, and a level interrupt. It sits on the shared CSR bus with the other CSR peripherals and drives the board tx/rx pins.

Parameters:
BASE_ADDR, 12'hbc0, data CSR address; status/control CSR is at BASE_ADDR+1.
CLOCK_RATE, 12_000_000, clk frequency in Hz.
BAUD_RATE, 115200, line rate; CLOCK_DIV = CLOCK_RATE/BAUD_RATE (16 bit, must be >= 4).
TX_DEPTH_LOG2, 3, TX FIFO depth = 2**TX_DEPTH_LOG2 (1..7).
RX_DEPTH_LOG2, 3, RX FIFO depth = 2**RX_DEPTH_LOG2 (1..7).

Ports:
clk  input  1  clock
rstn  input  1  reset; synchronous, active-low
read  input  1  CSR read strobe (unused; reads are side-effect free)
modify  input  3  001 write, 010 set, 011 clear, others no-op
wdata  input  32  CSR write data
addr  input  12  CSR address
rdata  output  32  registered read data, 0 when address not matched
valid  output  1  registered, 1 when the previous-cycle addr matched either CSR
rx  input  1  serial in, asynchronous
tx  output  1  serial out, idle high
irq  output  1  registered level interrupt

Behaviour:
- CSR timing: valid/rdata are updated every cycle from the current addr, giving 1-cycle latency. rdata reflects state before any same-cycle modify.
- Data CSR (BASE_ADDR) read: {22'b0, tx_full, rx_empty, rx_head[7:0]}; rx_head = 0 when the RX FIFO is empty.
- Data CSR write (001): push wdata[7:0] to the TX FIFO. Silently dropped if TX is full, unless the TX engine pops in the same cycle, in which case the push is accepted.
- Data CSR set (010), any wdata: pop the RX FIFO; no-op if empty.
- Status CSR (BASE_ADDR+1) read: [31:24]=0, [23:16]=tx_count, [15:8]=rx_count, [4]=frame_err, [3]=overrun, [2]=tx_busy, [1]=ie_tx, [0]=ie_rx. Counts are zero-extended.
- Status CSR write (001): ie_tx <= wdata[1], ie_rx <= wdata[0].
- Status CSR clear (011): wdata[3]=1 clears overrun, wdata[4]=1 clears frame_err.
- Status CSR set (010): no-op.
- FIFOs: circular buffers with a count of DEPTH_LOG2+1 bits, so full = count==depth. Simultaneous push+pop keeps count unchanged and is legal when full or empty-with-push.
- RX synchroniser: 2 flops on rx; all RX logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synced low moves to START and loads counter = CLOCK_DIV/2.
  - START at count 0: if the line is still low, go to DATA; otherwise it was a glitch, return to IDLE.
  - DATA: sample every CLOCK_DIV cycles, 8 bits LSB first.
  - STOP: sample once. If the line is high, push the byte. If RX is full and not popped the same cycle, drop the byte and set overrun. If the stop sample is low, discard the byte, set frame_err, and stay in STOP until the line is high, then go to IDLE.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the TX FIFO is non-empty, pop one byte, drive tx=0, go to START.
  - Each bit lasts exactly CLOCK_DIV cycles: start 0, 8 data bits LSB first, stop 1.
  - After STOP, return to IDLE; the next byte starts in the immediately following cycle, with no extra idle bit.
  - tx_busy = state != IDLE.
- irq (registered) = (ie_rx & !rx_empty) | (ie_tx & tx_count==0 & !tx_busy).
- Reset values:
  - Outputs: tx=1, irq=0, valid=0, rdata=0.
  - Internal: both FIFOs empty, both FSMs IDLE, overrun, frame_err, ie_tx and ie_rx all 0.
  - Reset mid-frame aborts the frame immediately; tx is 1 from the first cycle after reset is sampled.

Test Plan:
1. CLOCK_RATE=16, BAUD_RATE=1 (CLOCK_DIV=16): write 0xA5 to BASE_ADDR -> tx falls 1 cycle later and holds each bit 16 cycles: 0,1,0,1,0,0,1,0,1,1. Status read during the frame shows tx_busy=1, tx_count=0.
2. Nine writes 0x01..0x09 in consecutive cycles while the line is busy -> tx_count=8, 0x09 dropped. Bytes 0x01..0x08 are sent back to back: 80 bit-times total, with no idle between frames.
3. Drive two 8N1 frames 0x3C and 0xC3 on rx -> data read = 0x0003C (rx_empty=0, byte 0x3C), rx_count=2. Set-pop, then read -> 0x000C3. Pop again -> rx_empty=1, rx_head=0.
4. With RX depth 8, receive 9 frames without popping -> rx_count=8, overrun=1, the 9th byte is lost. Clear with wdata=0x8 -> overrun=0.
5. Frame with stop bit 0 -> no push, frame_err=1. A 2-cycle rx glitch in IDLE -> no frame, FSM returns to IDLE.
6. Write ie=0x3 with FIFOs empty -> irq=1 two cycles later. Write one TX byte -> irq falls once the byte is popped and tx_busy rises. Assert rstn low mid-frame -> tx=1, irq=0, all counts 0.
